// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin sharing of one external combinational adder
module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    output logic                     add_cin,
    input  logic [WIDTH-1:0]         add_y,
    input  logic                     add_cout,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [WIDTH-1:0]         resp_sum,
    output logic                     resp_cout,
    output logic                     resp_ovf,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    cap_id_q;
    logic [WIDTH-1:0]   add_a_q;
    logic [WIDTH-1:0]   add_b_q;
    logic               add_cin_q;
    logic               resp_valid_q;
    logic [ID_W-1:0]    resp_id_q;
    logic [WIDTH-1:0]   resp_sum_q;
    logic               resp_cout_q;
    logic               resp_ovf_q;

    logic [WIDTH-1:0]   a_arr [NUM_REQ];
    logic [WIDTH-1:0]   b_arr [NUM_REQ];
    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    next_ptr;
    logic               accept_window;
    logic               accept;

    // Unpack the flat operand buses so the grant index can select a lane directly
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
        assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end

    // Round-robin search: first valid requester at or after the pointer, wrapping
    always_comb begin
        logic [ID_W-1:0] idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    // Pointer moves to the requester after the one just granted
    assign next_ptr = ID_W'((int'(grant_idx) + 1) % NUM_REQ);

    // A new operation may start when idle, or when the held result is being drained
    assign accept_window = (state_q == IDLE) || ((state_q == RESP) && resp_ready);
    assign accept        = accept_window && grant_found;

    // One-hot ready to the granted requester; held low during reset
    always_comb begin
        req_ready = '0;
        if (rst_n && accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Arbitration FSM: capture operands, sample the adder one cycle later, hold the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            cap_id_q     <= '0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            add_cin_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_sum_q   <= '0;
            resp_cout_q  <= 1'b0;
            resp_ovf_q   <= 1'b0;
        end else begin
            if (accept) begin
                add_a_q   <= a_arr[grant_idx];
                add_b_q   <= b_arr[grant_idx];
                add_cin_q <= req_cin[grant_idx];
                cap_id_q  <= grant_idx;
                rr_ptr_q  <= next_ptr;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    resp_sum_q   <= add_y;
                    resp_cout_q  <= add_cout;
                    resp_id_q    <= cap_id_q;
                    resp_ovf_q   <= (add_a_q[WIDTH-1] == add_b_q[WIDTH-1]) &&
                                    (add_y[WIDTH-1] != add_a_q[WIDTH-1]);
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= accept ? EXEC : IDLE;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign add_cin    = add_cin_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_sum   = resp_sum_q;
    assign resp_cout  = resp_cout_q;
    assign resp_ovf   = resp_ovf_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - directed bench for adder_share_arbiter
module tb_adder_share_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_cin;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic           add_cin;
    logic [W-1:0]   add_y;
    logic           add_cout;
    logic           resp_valid;
    logic           resp_ready;
    logic [IW-1:0]  resp_id;
    logic [W-1:0]   resp_sum;
    logic           resp_cout;
    logic           resp_ovf;
    logic           busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Stand-in for the shared combinational adder
    assign {add_cout, add_y} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    adder_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_cin    (add_cin),
        .add_y      (add_y),
        .add_cout   (add_cout),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .resp_ovf   (resp_ovf),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin, input logic [W-1:0] es, input logic ec,
                             input logic eo);
        req_a[r*W +: W] = a;
        req_b[r*W +: W] = b;
        req_cin[r]      = cin;
        req_valid       = '0;
        req_valid[r]    = 1'b1;
        #1;
        chk("grant_onehot", 32'(req_ready), 32'(1 << r));
        tick();
        req_valid = '0;
        #1;
        chk("exec_resp_valid", 32'(resp_valid), 32'd0);
        chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_add_a", add_a, a);
        chk("exec_add_b", add_b, b);
        chk("exec_ready_low", 32'(req_ready), 32'd0);
        tick();
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_id", 32'(resp_id), 32'(r));
        chk("resp_sum", resp_sum, es);
        chk("resp_cout", 32'(resp_cout), 32'(ec));
        chk("resp_ovf", 32'(resp_ovf), 32'(eo));
        tick();
        chk("idle_resp_valid", 32'(resp_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int order [5];
        order = '{0, 1, 2, 3, 0};

        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_cin    = '0;
        resp_ready = 1'b1;

        // Reset values
        #3;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_add_a", add_a, 32'd0);
        chk("rst_resp_sum", resp_sum, 32'd0);
        req_valid = 4'b1111;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;

        // Single requesters: rr_ptr walks 0 -> 1 -> 3 -> 2
        single_op(0, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
        single_op(2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        single_op(1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        single_op(3, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);

        // Stalled response with requester 3 waiting (rr_ptr is 0 here)
        resp_ready    = 1'b0;
        req_a[0*W +: W] = 32'h0000_0001;
        req_b[0*W +: W] = 32'h0000_0002;
        req_cin[0]    = 1'b0;
        req_valid     = 4'b0001;
        #1;
        chk("stall_grant0", 32'(req_ready), 32'h1);
        tick();
        req_valid       = 4'b1000;
        req_a[3*W +: W] = 32'h0000_0010;
        req_b[3*W +: W] = 32'h0000_0020;
        req_cin[3]      = 1'b1;
        #1;
        chk("stall_exec_ready", 32'(req_ready), 32'd0);
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", 32'(resp_valid), 32'd1);
            chk("stall_id", 32'(resp_id), 32'd0);
            chk("stall_sum", resp_sum, 32'h0000_0003);
            chk("stall_ready", 32'(req_ready), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        chk("unstall_grant3", 32'(req_ready), 32'h8);
        tick();
        req_valid  = '0;
        resp_ready = 1'b0;
        #1;
        chk("unstall_exec_valid", 32'(resp_valid), 32'd0);
        tick();
        chk("unstall_resp_valid", 32'(resp_valid), 32'd1);
        chk("unstall_resp_id", 32'(resp_id), 32'd3);
        chk("unstall_resp_sum", resp_sum, 32'h0000_0031);

        // Asynchronous reset while a response is held
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = 32'(i * 32'h100);
            req_b[i*W +: W] = 32'(i + 1);
            req_cin[i]      = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        tick();
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        #1;

        // All requesters active: 0,1,2,3,0 with a grant every two cycles
        for (int k = 0; k < 5; k++) begin
            chk("rr_grant", 32'(req_ready), 32'(1 << order[k]));
            tick();
            chk("rr_exec_valid", 32'(resp_valid), 32'd0);
            tick();
            chk("rr_resp_valid", 32'(resp_valid), 32'd1);
            chk("rr_resp_id", 32'(resp_id), 32'(order[k]));
            chk("rr_resp_sum", resp_sum, 32'(order[k] * 32'h100 + order[k] + 1));
            if (k == 4) begin
                req_valid = '0;
                #1;
            end
        end
        tick();
        chk("final_busy", 32'(busy), 32'd0);
        chk("final_resp_valid", 32'(resp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
